// File: rtl/acia_fifo_bridge.sv
// 6551-style host/uc bridge with parametrised TX and RX FIFOs.
// Status, IRQ and uc event flags are derived from FIFO state and control registers.
module acia_fifo_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       host_sel,
  input  logic       host_r_w,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       _host_int,
  input  logic       uc_sel,
  input  logic       uc_r_w,
  input  logic [2:0] uc_addr,
  input  logic [7:0] uc_wdata,
  output logic [7:0] uc_rdata,
  output logic       _uc_int
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [TAW:0] tx_cnt;
  logic [RAW:0] rx_cnt;

  logic [7:0] cmd, ctrl, line_stat;
  logic overrun, ev_cmd, ev_ctrl, ev_preset, ev_txovf;

  logic host_rd, host_wr, uc_rd, uc_wr;
  logic prog_reset, cmd_wr, ctrl_wr, flag_rd;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push, tx_ovf, rx_pop, rx_push, rx_ovf;
  logic tdre, rdrf, irq;
  logic [7:0] status, ev_flags, tx_cnt8, rx_cnt8;

  assign host_rd = host_sel & host_r_w;
  assign host_wr = host_sel & ~host_r_w;
  assign uc_rd   = uc_sel & uc_r_w;
  assign uc_wr   = uc_sel & ~uc_r_w;

  assign prog_reset = host_wr & (host_addr == 2'd1);
  assign cmd_wr     = host_wr & (host_addr == 2'd2);
  assign ctrl_wr    = host_wr & (host_addr == 2'd3);
  assign flag_rd    = uc_rd & (uc_addr == 3'd1);

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULL);

  // A pop on the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_pop  = uc_rd & (uc_addr == 3'd0) & ~tx_empty & ~prog_reset;
  assign tx_push = host_wr & (host_addr == 2'd0) & (~tx_full | tx_pop);
  assign tx_ovf  = host_wr & (host_addr == 2'd0) & ~tx_push;
  assign rx_pop  = host_rd & (host_addr == 2'd0) & ~rx_empty;
  assign rx_push = uc_wr & (uc_addr == 3'd0) & ~prog_reset & (~rx_full | rx_pop);
  assign rx_ovf  = uc_wr & (uc_addr == 3'd0) & ~prog_reset & ~rx_push;

  always_comb begin
    tx_cnt8 = '0;
    rx_cnt8 = '0;
    tx_cnt8[TAW:0] = tx_cnt;
    rx_cnt8[RAW:0] = rx_cnt;
    tdre = ~tx_full;
    rdrf = ~rx_empty;
    irq = cmd[0] & ((rdrf & ~cmd[1]) | (tdre & (cmd[3:2] == 2'b01)));
    status = {irq, line_stat[6], line_stat[5], tdre, rdrf, overrun,
              line_stat[1], line_stat[0]};
    ev_flags = {2'b00, ev_txovf, rx_full, ev_preset, ev_ctrl, ev_cmd, ~tx_empty};
  end

  assign _host_int = ~irq;
  assign _uc_int   = ~(~tx_empty | ev_cmd | ev_ctrl | ev_preset | ev_txovf);

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr] <= host_wdata;
    if (rx_push) rx_mem[rx_wr] <= uc_wdata;
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
      tx_cnt <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
      rx_cnt <= '0;
    end else if (prog_reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
      tx_cnt <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TAW'(1);
      if (tx_pop) tx_rd <= tx_rd + TAW'(1);
      if (tx_push && !tx_pop) tx_cnt <= tx_cnt + (TAW+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - (TAW+1)'(1);
      if (rx_push) rx_wr <= rx_wr + RAW'(1);
      if (rx_pop) rx_rd <= rx_rd + RAW'(1);
      if (rx_push && !rx_pop) rx_cnt <= rx_cnt + (RAW+1)'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - (RAW+1)'(1);
    end
  end

  // Sticky flags: a new event on the same cycle as the clearing read wins.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      cmd <= 8'h02;
      ctrl <= 8'h10;
      line_stat <= 8'h00;
      overrun <= 1'b0;
      ev_cmd <= 1'b0;
      ev_ctrl <= 1'b0;
      ev_preset <= 1'b0;
      ev_txovf <= 1'b0;
    end else begin
      if (prog_reset) cmd <= {cmd[7:5], 5'b00010};
      else if (cmd_wr) cmd <= host_wdata;
      if (ctrl_wr) ctrl <= host_wdata;
      if (uc_wr && uc_addr == 3'd1) line_stat <= uc_wdata & 8'h63;
      if (prog_reset) overrun <= 1'b0;
      else if (rx_ovf) overrun <= 1'b1;
      else if (host_rd && host_addr == 2'd0) overrun <= 1'b0;
      ev_cmd <= (ev_cmd & ~flag_rd) | cmd_wr;
      ev_ctrl <= (ev_ctrl & ~flag_rd) | ctrl_wr;
      ev_preset <= (ev_preset & ~flag_rd) | prog_reset;
      ev_txovf <= (ev_txovf & ~flag_rd) | tx_ovf;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      host_rdata <= 8'h00;
      uc_rdata <= 8'h00;
    end else begin
      if (host_rd) begin
        case (host_addr)
          2'd0: host_rdata <= rx_empty ? 8'h00 : rx_mem[rx_rd];
          2'd1: host_rdata <= status;
          2'd2: host_rdata <= cmd;
          default: host_rdata <= ctrl;
        endcase
      end
      if (uc_rd) begin
        case (uc_addr)
          3'd0: uc_rdata <= tx_pop ? tx_mem[tx_rd] : 8'h00;
          3'd1: uc_rdata <= ev_flags;
          3'd2: uc_rdata <= cmd;
          3'd3: uc_rdata <= ctrl;
          3'd4: uc_rdata <= tx_cnt8;
          3'd5: uc_rdata <= rx_cnt8;
          default: uc_rdata <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acia_fifo_bridge.sv
// Scoreboard bench for acia_fifo_bridge: queue-based reference model predicts
// every read and the interrupt lines; a monitor compares after each edge.
module tb_acia_fifo_bridge;

  localparam int TXD = 8;
  localparam int RXD = 4;

  logic clock = 1'b0;
  logic _reset;
  logic host_sel, host_r_w, uc_sel, uc_r_w;
  logic [1:0] host_addr;
  logic [2:0] uc_addr;
  logic [7:0] host_wdata, uc_wdata, host_rdata, uc_rdata;
  logic _host_int, _uc_int;

  always #5 clock = ~clock;

  acia_fifo_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clock(clock), ._reset(_reset),
    .host_sel(host_sel), .host_r_w(host_r_w), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), ._host_int(_host_int),
    .uc_sel(uc_sel), .uc_r_w(uc_r_w), .uc_addr(uc_addr),
    .uc_wdata(uc_wdata), .uc_rdata(uc_rdata), ._uc_int(_uc_int)
  );

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_cmd, m_ctrl, m_line;
  bit m_ovr, f_cmd, f_ctrl, f_rst, f_ovf;

  // Scoreboard queues
  logic [7:0] host_exp[$];
  logic [7:0] uc_exp[$];
  logic [1:0] int_exp[$];

  int total = 0;
  int bad = 0;
  bit mon_hr, mon_ur;

  function automatic bit m_irq();
    bit tdre, rdrf;
    tdre = tx_q.size() < TXD;
    rdrf = rx_q.size() != 0;
    return m_cmd[0] && ((rdrf && !m_cmd[1]) || (tdre && m_cmd[3:2] == 2'b01));
  endfunction

  function automatic logic [7:0] m_status();
    return {m_irq(), m_line[6], m_line[5], tx_q.size() < TXD, rx_q.size() != 0,
            m_ovr, m_line[1], m_line[0]};
  endfunction

  function automatic logic [7:0] m_flags();
    return {2'b00, f_ovf, rx_q.size() == RXD, f_rst, f_ctrl, f_cmd, tx_q.size() != 0};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%02h want=%02h at %0t", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic hs, input logic hrw, input logic [1:0] ha,
                               input logic [7:0] hwd, input logic us, input logic urw,
                               input logic [2:0] ua, input logic [7:0] uwd);
    logic [7:0] e;
    bit preset, uc_irq;
    @(negedge clock);
    host_sel = hs; host_r_w = hrw; host_addr = ha; host_wdata = hwd;
    uc_sel = us; uc_r_w = urw; uc_addr = ua; uc_wdata = uwd;
    preset = hs && !hrw && ha == 2'd1;
    if (hs && hrw) begin
      case (ha)
        2'd0: e = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        2'd1: e = m_status();
        2'd2: e = m_cmd;
        default: e = m_ctrl;
      endcase
      host_exp.push_back(e);
    end
    if (us && urw) begin
      case (ua)
        3'd0: e = (tx_q.size() != 0 && !preset) ? tx_q[0] : 8'h00;
        3'd1: e = m_flags();
        3'd2: e = m_cmd;
        3'd3: e = m_ctrl;
        3'd4: e = 8'(tx_q.size());
        3'd5: e = 8'(rx_q.size());
        default: e = 8'h00;
      endcase
      uc_exp.push_back(e);
    end
    if (us && urw && ua == 3'd1) begin
      f_cmd = 0; f_ctrl = 0; f_rst = 0; f_ovf = 0;
    end
    if (hs && hrw && ha == 2'd0) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      m_ovr = 0;
    end
    if (!preset) begin
      if (us && urw && ua == 3'd0 && tx_q.size() != 0) void'(tx_q.pop_front());
      if (us && !urw && ua == 3'd0) begin
        if (rx_q.size() < RXD) rx_q.push_back(uwd);
        else m_ovr = 1;
      end
    end
    if (hs && !hrw && ha == 2'd0) begin
      if (tx_q.size() < TXD) tx_q.push_back(hwd);
      else f_ovf = 1;
    end
    if (hs && !hrw && ha == 2'd2) begin m_cmd = hwd; f_cmd = 1; end
    if (hs && !hrw && ha == 2'd3) begin m_ctrl = hwd; f_ctrl = 1; end
    if (us && !urw && ua == 3'd1) m_line = uwd & 8'h63;
    if (preset) begin
      m_cmd = {m_cmd[7:5], 5'b00010};
      tx_q.delete();
      rx_q.delete();
      m_ovr = 0;
      f_rst = 1;
    end
    uc_irq = (tx_q.size() != 0) || f_cmd || f_ctrl || f_rst || f_ovf;
    int_exp.push_back({~m_irq(), ~uc_irq});
  endtask

  task automatic hostOp(input logic rw, input logic [1:0] a, input logic [7:0] d);
    applyStimulus(1'b1, rw, a, d, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic ucOp(input logic rw, input logic [2:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, rw, a, d);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // Monitor: each edge that saw a read retires one scoreboard entry.
  initial begin
    forever begin
      @(posedge clock);
      mon_hr = host_sel && host_r_w && _reset;
      mon_ur = uc_sel && uc_r_w && _reset;
      #1;
      if (int_exp.size() != 0) begin
        logic [1:0] ie;
        ie = int_exp.pop_front();
        checkOutput("host_int", {7'd0, _host_int}, {7'd0, ie[1]});
        checkOutput("uc_int", {7'd0, _uc_int}, {7'd0, ie[0]});
      end
      if (mon_hr) begin
        if (host_exp.size() != 0) checkOutput("host_rdata", host_rdata, host_exp.pop_front());
        else checkOutput("host_rdata_unexpected", host_rdata, 8'hxx);
      end
      if (mon_ur) begin
        if (uc_exp.size() != 0) checkOutput("uc_rdata", uc_rdata, uc_exp.pop_front());
        else checkOutput("uc_rdata_unexpected", uc_rdata, 8'hxx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    _reset = 1'b0;
    host_sel = 0; host_r_w = 0; host_addr = 0; host_wdata = 0;
    uc_sel = 0; uc_r_w = 0; uc_addr = 0; uc_wdata = 0;
    m_cmd = 8'h02; m_ctrl = 8'h10; m_line = 8'h00;
    m_ovr = 0; f_cmd = 0; f_ctrl = 0; f_rst = 0; f_ovf = 0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_host_rdata", host_rdata, 8'h00);
    checkOutput("rst_uc_rdata", uc_rdata, 8'h00);
    checkOutput("rst_host_int", {7'd0, _host_int}, 8'h01);
    checkOutput("rst_uc_int", {7'd0, _uc_int}, 8'h01);
    @(negedge clock);
    _reset = 1'b1;

    // Reset register values
    hostOp(1, 2'd1, 0); hostOp(1, 2'd2, 0); hostOp(1, 2'd3, 0);

    // Host to uc transfer
    hostOp(0, 2'd0, 8'h41); hostOp(0, 2'd0, 8'h42);
    ucOp(1, 3'd4, 0); ucOp(1, 3'd0, 0); ucOp(1, 3'd0, 0); ucOp(1, 3'd4, 0);

    // RX interrupt path
    hostOp(0, 2'd2, 8'h09); ucOp(1, 3'd1, 0);
    ucOp(0, 3'd0, 8'h55); hostOp(1, 2'd1, 0); hostOp(1, 2'd0, 0); hostOp(1, 2'd1, 0);

    // RX overrun
    for (int i = 0; i <= RXD; i++) ucOp(0, 3'd0, 8'($urandom));
    hostOp(1, 2'd1, 0); ucOp(1, 3'd1, 0);
    hostOp(1, 2'd0, 0); hostOp(1, 2'd1, 0);
    for (int i = 1; i < RXD; i++) hostOp(1, 2'd0, 0);
    hostOp(1, 2'd0, 0); hostOp(1, 2'd1, 0);

    // TX full with simultaneous push/pop, then overflow
    for (int i = 0; i < TXD; i++) hostOp(0, 2'd0, 8'(8'hA0 + i));
    ucOp(1, 3'd1, 0);
    applyStimulus(1, 0, 2'd0, 8'hEE, 1, 1, 3'd0, 0);
    ucOp(1, 3'd4, 0); ucOp(1, 3'd1, 0);
    hostOp(0, 2'd0, 8'hEF); ucOp(1, 3'd1, 0);

    // Programmed reset
    hostOp(0, 2'd2, 8'hEB); ucOp(0, 3'd0, 8'h77);
    ucOp(1, 3'd1, 0);
    hostOp(0, 2'd1, 8'h5A);
    hostOp(1, 2'd2, 0); ucOp(1, 3'd4, 0); ucOp(1, 3'd5, 0);
    ucOp(1, 3'd1, 0); ucOp(1, 3'd1, 0);
    ucOp(0, 3'd1, 8'hFF); hostOp(1, 2'd1, 0); ucOp(1, 3'd6, 0); ucOp(1, 3'd7, 0);

    // Randomised traffic, independent host and uc accesses
    for (int i = 0; i < 4000; i++) begin
      logic hs, hrw, us, urw;
      logic [1:0] ha;
      logic [2:0] ua;
      hs = ($urandom_range(0, 3) != 0);
      hrw = $urandom_range(0, 1) == 1;
      ha = 2'($urandom_range(0, 3));
      if (ha == 2'd1 && !hrw && $urandom_range(0, 15) != 0) hrw = 1;
      if (ha >= 2'd2 && $urandom_range(0, 1) == 1) ha = 2'd0;
      us = ($urandom_range(0, 3) != 0);
      urw = $urandom_range(0, 1) == 1;
      ua = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      applyStimulus(hs, hrw, ha, 8'($urandom), us, urw, ua, 8'($urandom));
    end

    idle(); idle();
    repeat (2) @(posedge clock);
    #2;
    checkOutput("sb_host_left", 8'(host_exp.size()), 8'h00);
    checkOutput("sb_uc_left", 8'(uc_exp.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acia_fifo_bridge.md
# acia_fifo_bridge

Single-clock, parametrised 6551-compatible bridge between a host 6502-style bus and a helper microcontroller. Host transmit and receive data pass through configurable-depth FIFOs instead of single-byte mailboxes. The status register, including the IRQ bit, is assembled in hardware from FIFO state, cmd and a uc-written line-status register. The uc side gets occupancy counts, sticky event flags and a level interrupt, so it can service the channel in bursts.

## Interface
- TX_DEPTH, 16, host→uc FIFO entries; power of two, 2..128
- RX_DEPTH, 16, uc→host FIFO entries; power of two, 2..128
- clock  in  1  sole clock; all state updates on rising edge
- _reset  in  1  asynchronous, active-low reset
- host_sel  in  1  one-cycle host access strobe
- host_r_w  in  1  1 = read, 0 = write (qualified by host_sel)
- host_addr  in  2  0 data, 1 status/programmed reset, 2 cmd, 3 ctrl
- host_wdata  in  8  host write data
- host_rdata  out  8  registered host read data
- _host_int  out  1  active-low host interrupt, level
- uc_sel  in  1  one-cycle uc access strobe
- uc_r_w  in  1  1 = read, 0 = write
- uc_addr  in  3  uc register select
- uc_wdata  in  8  uc write data
- uc_rdata  out  8  registered uc read data
- _uc_int  out  1  active-low uc interrupt, level

## Operation
- Host map:
  - addr0 R pops RX FIFO; W pushes TX FIFO.
  - addr1 R returns status; W performs programmed reset (data ignored).
  - addr2 and addr3 R/W cmd and ctrl.
- Status bits: 7 IRQ, 6 DSR, 5 DCD, 4 TDRE (TX not full), 3 RDRF (RX not empty), 2 overrun, 1 framing, 0 parity. Bits 6,5,1,0 come from uc line-status register.
- IRQ = cmd[0] & ((RDRF & !cmd[1]) | (TDRE & cmd[3:2]==2'b01)). _host_int = !IRQ.
- Overrun: set when uc pushes into a full RX FIFO; cleared by host addr0 read.
- uc map:
  - 0 R pops TX FIFO; W pushes RX FIFO.
  - 1 R returns event flags; W loads line-status bits 6,5,1,0.
  - 2 R cmd. 3 R ctrl. 4 R TX count. 5 R RX count. 6,7 R 0x00.
  - Writes to 2..7 are ignored.
- Event flags, sticky, cleared by uc addr1 read: bit1 cmd written, bit2 ctrl written, bit3 programmed reset, bit5 TX overflow (host push into full TX). Live bits: bit0 TX not empty, bit4 RX full. Bits 7,6 read 0.
- _uc_int = !(TX not empty | any sticky flag).
- Push to full FIFO: data dropped, pointers unchanged, flag set. Exception: a pop on the same cycle makes room, so the push is accepted.
- Pop from empty FIFO: returns 0x00, pointers unchanged.
- Programmed reset:
  - cmd[4:0] ← 5'b00010; cmd[7:5] kept; ctrl kept.
  - Both FIFOs flushed; overrun cleared; uc event bit3 set.
  - A uc push or pop on the same cycle is discarded.
- Counts: width clog2(DEPTH)+1, zero-extended to 8 bits. Pointers wrap modulo DEPTH.

## Timing
- _reset low:
  - cmd = 0x02, ctrl = 0x10, line-status = 0.
  - FIFOs empty, all flags 0.
  - host_rdata = uc_rdata = 0x00.
  - _host_int = _uc_int = 1.
- Access sampled at edge N when sel = 1. Read data appears on rdata after edge N, held until the next read.
- Pop/push/flag effects are visible in state, status and counts after edge N. Interrupts are combinational from registered state, so they move after edge N.
- Status read at edge N returns pre-edge state. A pop at edge N is not reflected in the returned value.
- Host and uc accesses on the same cycle are independent. Count = old + push − pop.
- A host read of RX and a uc push of RX on the same cycle, with the FIFO empty: the push is accepted and the pop returns 0x00.

## Test plan
- Reset, then host reads addr1, addr2, addr3 → 0x10, 0x02, 0x10 (TDRE set). _host_int = 1, _uc_int = 1.
- Host writes 0x41, 0x42 to addr0 → uc addr4 = 0x02, _uc_int = 0. uc pops → 0x41, then 0x42. Count 0, _uc_int = 1.
- Host writes cmd 0x09; uc pushes 0x55 → status = 0x98, _host_int = 0. Host addr0 read → 0x55, then status = 0x10, _host_int = 1.
- uc pushes RX_DEPTH+1 bytes → status bit2 = 1 and uc flag bit4 = 1. Host reads all RX_DEPTH bytes → first-pushed values in order; overrun cleared after the first read.
- Fill TX, then host push plus uc pop on the same cycle → accepted, TX count still TX_DEPTH, no overflow flag. One further host push → uc flag bit5 = 1.
- With cmd = 0xEB and both FIFOs non-empty, host writes addr1 → cmd = 0xE2, counts 0, uc flags read 0x08, then 0x00.
